// File: rtl/multi_key_debouncer.sv
// multi_key_debouncer: debounces a bank of keys with shared sample tick and press/release pulses
// Ports:
//   iwClk          system clock
//   iwRst          asynchronous reset, active-high
//   iwKeyIn        raw asynchronous key levels, one bit per channel
//   orKeyOut       debounced key levels, raw polarity preserved
//   orPressPulse   one-cycle pulse when a channel becomes pressed (or auto-repeats)
//   orReleasePulse one-cycle pulse when a channel becomes released
// Build option: define MULTI_KEY_DEBOUNCER_REPEAT_EN to enable auto-repeat of press pulses.
module multi_key_debouncer #(
    parameter int pChannels           = 4,
    parameter int pClockDividerFactor = 1000000,
    parameter int pSampleTime         = 15,
    parameter bit pActiveLow          = 1'b1,
    parameter int pRepeatDelay        = 500,
    parameter int pRepeatPeriod       = 100
) (
    input  logic                 iwClk,
    input  logic                 iwRst,
    input  logic [pChannels-1:0] iwKeyIn,
    output logic [pChannels-1:0] orKeyOut,
    output logic [pChannels-1:0] orPressPulse,
    output logic [pChannels-1:0] orReleasePulse
);
    localparam int lDiv    = (pClockDividerFactor < 2) ? 1 : pClockDividerFactor;
    localparam int lPw     = (lDiv > 2) ? $clog2(lDiv) : 1;
    localparam int lSample = (pSampleTime < 1) ? 1 : pSampleTime;
    localparam int lCw     = $clog2(lSample + 1);
    localparam logic [lCw-1:0] lLast = lCw'(lSample - 1);
    localparam logic lPressed = ~pActiveLow;
    localparam logic [pChannels-1:0] lIdle = {pChannels{pActiveLow}};

    logic [pChannels-1:0] rSyncMeta;
    logic [pChannels-1:0] rSyncKey;
    logic [lPw-1:0]       rDiv;
    logic [lCw-1:0]       rCnt [pChannels];
    logic                 wTick;
    logic [pChannels-1:0] wAccept;

    // A divider of 1 ticks every cycle; otherwise the tick is the wrap cycle.
    assign wTick = (lDiv == 1) ? 1'b1 : (rDiv == lPw'(lDiv - 1));

    always_comb begin
        wAccept = '0;
        for (int i = 0; i < pChannels; i++)
            wAccept[i] = wTick && (rSyncKey[i] != orKeyOut[i]) && (rCnt[i] == lLast);
    end

`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
    localparam int lDelay  = (pRepeatDelay < 1) ? 1 : pRepeatDelay;
    localparam int lPeriod = (pRepeatPeriod < 1) ? 1 : pRepeatPeriod;
    localparam int lRw     = $clog2(((lDelay > lPeriod) ? lDelay : lPeriod) + 1);

    // Ticks remaining until the next repeat pulse; zero means disarmed.
    logic [lRw-1:0] rRep [pChannels];

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            for (int i = 0; i < pChannels; i++) rRep[i] <= '0;
        end else begin
            for (int i = 0; i < pChannels; i++) begin
                if (wAccept[i])
                    rRep[i] <= (rSyncKey[i] == lPressed) ? lRw'(lDelay) : '0;
                else if (orKeyOut[i] != lPressed)
                    rRep[i] <= '0;
                else if (wTick && rRep[i] != '0)
                    rRep[i] <= (rRep[i] == lRw'(1)) ? lRw'(lPeriod) : rRep[i] - 1'b1;
            end
        end
    end

    // A repeat fires on a tick where the armed count expires and no release is being accepted.
    logic [pChannels-1:0] wRepeat;
    always_comb begin
        wRepeat = '0;
        for (int i = 0; i < pChannels; i++)
            wRepeat[i] = wTick && !wAccept[i] && (orKeyOut[i] == lPressed) && (rRep[i] == lRw'(1));
    end
`else
    logic [pChannels-1:0] wRepeat;
    assign wRepeat = '0;
`endif

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            rSyncMeta      <= lIdle;
            rSyncKey       <= lIdle;
            rDiv           <= '0;
            orKeyOut       <= lIdle;
            orPressPulse   <= '0;
            orReleasePulse <= '0;
            for (int i = 0; i < pChannels; i++) rCnt[i] <= '0;
        end else begin
            rSyncMeta <= iwKeyIn;
            rSyncKey  <= rSyncMeta;
            rDiv      <= wTick ? '0 : rDiv + 1'b1;
            for (int i = 0; i < pChannels; i++) begin
                orPressPulse[i]   <= wRepeat[i] || (wAccept[i] && rSyncKey[i] == lPressed);
                orReleasePulse[i] <= wAccept[i] && rSyncKey[i] != lPressed;
                if (wTick) begin
                    // Any sample matching the current output restarts qualification.
                    if (rSyncKey[i] == orKeyOut[i]) rCnt[i] <= '0;
                    else if (wAccept[i]) begin
                        orKeyOut[i] <= rSyncKey[i];
                        rCnt[i]     <= '0;
                    end else rCnt[i] <= rCnt[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_key_debouncer.sv
// tb_multi_key_debouncer: directed self-checking bench for multi_key_debouncer
module tb_multi_key_debouncer;
    logic       iwClk = 1'b0;
    logic       iwRst;
    logic [3:0] iwKeyIn;
    logic [3:0] orKeyOut;
    logic [3:0] orPressPulse;
    logic [3:0] orReleasePulse;

    int nChecks = 0;
    int nErrors = 0;
    int nPress;
    int nRel;
    int firstRep;
    int lat;
    bit seen;

    multi_key_debouncer #(
        .pChannels(4),
        .pClockDividerFactor(4),
        .pSampleTime(3),
        .pActiveLow(1'b1),
        .pRepeatDelay(5),
        .pRepeatPeriod(2)
    ) dut (
        .iwClk(iwClk),
        .iwRst(iwRst),
        .iwKeyIn(iwKeyIn),
        .orKeyOut(orKeyOut),
        .orPressPulse(orPressPulse),
        .orReleasePulse(orReleasePulse)
    );

    always #5 iwClk = ~iwClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge iwClk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with every key held pressed; edges counted from reset release.
        iwRst = 1'b1;
        iwKeyIn = 4'h0;
        step(3);
        check("rst_key", orKeyOut, 4'hF);
        check("rst_press", orPressPulse, 4'h0);
        check("rst_rel", orReleasePulse, 4'h0);
        iwRst = 1'b0;
        step(11);
        check("all_pre_key", orKeyOut, 4'hF);
        check("all_pre_press", orPressPulse, 4'h0);
        step(1);
        check("all_key", orKeyOut, 4'h0);
        check("all_press", orPressPulse, 4'hF);
        check("all_rel", orReleasePulse, 4'h0);
        step(1);
        check("all_press_once", orPressPulse, 4'h0);

        // Clean press on ch0: accepted on the 3rd tick (edge 12).
        iwRst = 1'b1;
        iwKeyIn = 4'hF;
        step(2);
        check("rst2_key", orKeyOut, 4'hF);
        iwRst = 1'b0;
        iwKeyIn = 4'hE;
        step(11);
        check("press_pre_key", orKeyOut, 4'hF);
        step(1);
        check("press_key", orKeyOut, 4'hE);
        check("press_pulse", orPressPulse, 4'h1);
        check("press_rel", orReleasePulse, 4'h0);
        step(1);
        check("press_once", orPressPulse, 4'h0);

        // Hold ch0 for 20 more ticks (edges 14..93).
        nPress = 0;
        nRel = 0;
        firstRep = 0;
        for (int i = 14; i <= 93; i++) begin
            step(1);
            if (orPressPulse[0]) begin
                nPress++;
                if (firstRep == 0) firstRep = i;
            end
            if (orReleasePulse != 4'h0) nRel++;
        end
        check("hold_rel", nRel, 0);
`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
        check("rep_count", nPress, 8);
        check("rep_first_edge", firstRep, 32);
`else
        check("hold_single", nPress, 0);
`endif

        // Release ch0: accepted at edge 104, which is also when a repeat would be due.
        iwKeyIn = 4'hF;
        nPress = 0;
        nRel = 0;
        for (int i = 94; i <= 103; i++) begin
            step(1);
            if (orPressPulse[0]) nPress++;
            if (orReleasePulse != 4'h0) nRel++;
        end
        check("rel_pre_key", orKeyOut, 4'hE);
        check("rel_pre_pulse", nRel, 0);
`ifdef MULTI_KEY_DEBOUNCER_REPEAT_EN
        check("rel_pre_rep", nPress, 1);
`else
        check("rel_pre_rep", nPress, 0);
`endif
        step(1);
        check("rel_key", orKeyOut, 4'hF);
        check("rel_pulse", orReleasePulse, 4'h1);
        check("rel_no_repeat", orPressPulse, 4'h0);
        step(1);
        check("rel_once", orReleasePulse, 4'h0);

        // Bounce on ch1: toggles every 5 clocks never reach 3 consecutive ticks.
        for (int t = 0; t < 12; t++) begin
            iwKeyIn[1] = ~iwKeyIn[1];
            for (int c = 0; c < 5; c++) begin
                step(1);
                check("bounce", {orKeyOut[1], orPressPulse[1], orReleasePulse[1]}, 3'b100);
            end
        end
        step(16);
        check("bounce_settle", orKeyOut, 4'hF);

        // Hold ch3, then press ch2 and release ch3 on the same clock.
        iwKeyIn = 4'h7;
        step(20);
        check("ch3_held", orKeyOut, 4'h7);
        iwKeyIn = 4'hB;
        seen = 1'b0;
        lat = 0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            step(1);
            if (orPressPulse != 4'h0 || orReleasePulse != 4'h0) begin
                seen = 1'b1;
                lat = c;
            end
        end
        check("sim_latency", lat, 11);
        check("sim_press", orPressPulse, 4'h4);
        check("sim_rel", orReleasePulse, 4'h8);
        check("sim_key", orKeyOut, 4'hB);

        // Reset in the middle of qualification discards the partial count.
        iwRst = 1'b1;
        iwKeyIn = 4'hF;
        step(2);
        iwRst = 1'b0;
        iwKeyIn = 4'hE;
        step(9);
        check("midq_pre_key", orKeyOut, 4'hF);
        iwRst = 1'b1;
        step(1);
        check("midq_rst_key", orKeyOut, 4'hF);
        check("midq_rst_press", orPressPulse, 4'h0);
        iwRst = 1'b0;
        step(11);
        check("midq_post_pre_key", orKeyOut, 4'hF);
        step(1);
        check("midq_key", orKeyOut, 4'hE);
        check("midq_press", orPressPulse, 4'h1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
